// File: rtl/ins_decode_pkg.sv
// Shared types for the decode stage: opcode constants, instruction formats,
// instruction field layout, the decoded bundle and the decode FSM states.
package ins_decode_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  typedef struct packed {
    logic [5:0] opcode;
    fmt_e       fmt;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [8:0] tail;
  } ins_fields_t;

  typedef struct packed {
    logic [5:0]  opcode;
    fmt_e        fmt;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] npc;
  } bundle_t;

  typedef enum logic [1:0] {IDLE, DECODE, STALL, HALTED} state_e;

  function automatic logic uses_rs1(fmt_e fmt);
    return fmt != FMT_J;
  endfunction

  function automatic logic uses_rs2(fmt_e fmt);
    return (fmt == FMT_R) || (fmt == FMT_B);
  endfunction

  function automatic logic writes_rd(fmt_e fmt, logic [4:0] rd, logic [5:0] opcode);
    return ((fmt == FMT_R) || (fmt == FMT_I)) && (rd != 5'd0) && (opcode != OP_NOP);
  endfunction

  // Takes ins[25:0]: format bits plus everything an immediate can span.
  function automatic logic [31:0] ext_imm(logic [25:0] low);
    case (fmt_e'(low[25:24]))
      FMT_I, FMT_B: return {{18{low[13]}}, low[13:0]};
      FMT_J:        return {{8{low[23]}}, low[23:0]};
      default:      return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/ins_decode_unit_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, r0 hardwired to zero.
module reg_file_32x32 #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int AW      = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [REG_CNT];

  // NOTE: the array is reset explicitly because reset must clear every
  // register; this forces flops rather than a RAM macro, which is fine at 32x32.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/ins_decode_unit.sv
// Decode stage: field split, operand read, scoreboard RAW stall, registered
// bundle to execute. Define WB_BYPASS_EN to forward same-cycle write-back data.
module ins_decode_unit
  import ins_decode_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ins_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              valid_in,
  input  logic              freeze,
  input  logic              flush_in,
  input  logic              wb_enable_in,
  input  logic [4:0]        wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  output logic              valid_out,
  output logic [5:0]        opcode_out,
  output logic [1:0]        format_out,
  output logic [4:0]        rd_addr_out,
  output logic [DATA_W-1:0] rs1_data_out,
  output logic [DATA_W-1:0] rs2_data_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] npc_out,
  output logic              stall_out,
  output logic              halt_out
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  hold_ins_q, hold_npc_q;
  logic [REG_CNT-1:0] sb_q, pend_q, busy_vec, wb_clr, sb_set;
  bundle_t            bundle_q, bundle_d;
  logic               valid_q, halt_q;

  logic [DATA_W-1:0]  cur_ins, cur_npc, rf_rd1, rf_rd2, op1, op2;
  ins_fields_t        f;
  logic               cur_vld, flush_act, byp1, byp2, hazard;
  logic               emit, to_stall, is_halt, wr_rd;

  // While stalled the held instruction is re-evaluated; fetch is ignored.
  assign cur_ins   = (state_q == STALL) ? hold_ins_q : ins_in;
  assign cur_npc   = (state_q == STALL) ? hold_npc_q : npc_in;
  assign cur_vld   = (state_q == STALL) || (((state_q == IDLE) || (state_q == DECODE)) && valid_in);
  assign f         = ins_fields_t'(cur_ins);
  assign is_halt   = (f.opcode == OP_HALT);
  assign wr_rd     = writes_rd(f.fmt, f.rd, f.opcode);
  // HALTED is only left through reset, so a redirect cannot wake it.
  assign flush_act = flush_in && (state_q != HALTED);

  reg_file_32x32 #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clock (clock),
    .reset (reset),
    .we    (wb_enable_in),
    .waddr (wb_addr_in),
    .wdata (wb_data_in),
    .raddr1(f.rs1),
    .raddr2(f.rs2),
    .rdata1(rf_rd1),
    .rdata2(rf_rd2)
  );

`ifdef WB_BYPASS_EN
  assign byp1 = wb_enable_in && (wb_addr_in != 5'd0) && (wb_addr_in == f.rs1);
  assign byp2 = wb_enable_in && (wb_addr_in != 5'd0) && (wb_addr_in == f.rs2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign op1 = byp1 ? wb_data_in : rf_rd1;
  assign op2 = byp2 ? wb_data_in : rf_rd2;

  // Clears queued during freeze already have their data in the register file.
  assign busy_vec = sb_q & ~pend_q;
  assign hazard   = (uses_rs1(f.fmt) && busy_vec[f.rs1] && !byp1) ||
                    (uses_rs2(f.fmt) && busy_vec[f.rs2] && !byp2);

  assign wb_clr = wb_enable_in ? (REG_CNT'(1) << wb_addr_in) : '0;
  assign sb_set = (emit && wr_rd) ? (REG_CNT'(1) << f.rd) : '0;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_act) begin
      state_d = IDLE;
    end else if (!freeze) begin
      unique case (state_q)
        IDLE, DECODE, STALL: begin
          if (emit)          state_d = is_halt ? HALTED : DECODE;
          else if (to_stall) state_d = STALL;
          else               state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    emit     = 1'b0;
    to_stall = 1'b0;
    if (cur_vld && !flush_act && !freeze) begin
      emit     = !hazard;
      to_stall = hazard;
    end
  end

  always_comb begin
    bundle_d          = '0;
    bundle_d.opcode   = f.opcode;
    bundle_d.fmt      = f.fmt;
    bundle_d.rd_addr  = wr_rd ? f.rd : 5'd0;
    bundle_d.rs1_data = uses_rs1(f.fmt) ? op1 : '0;
    bundle_d.rs2_data = uses_rs2(f.fmt) ? op2 : '0;
    bundle_d.imm      = ext_imm(f[25:0]);
    bundle_d.npc      = cur_npc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      bundle_q   <= '0;
      hold_ins_q <= '0;
      hold_npc_q <= '0;
      sb_q       <= '0;
      pend_q     <= '0;
    end else begin
      if (!freeze || flush_act) valid_q <= emit;
      if (emit) begin
        bundle_q <= bundle_d;
        if (is_halt) halt_q <= 1'b1;
      end
      if (to_stall) begin
        hold_ins_q <= cur_ins;
        hold_npc_q <= cur_npc;
      end
      // Set wins over a same-cycle clear: the new issue is the younger writer.
      if (freeze) begin
        pend_q <= pend_q | wb_clr;
      end else begin
        sb_q   <= (sb_q & ~(pend_q | wb_clr)) | sb_set;
        pend_q <= '0;
      end
    end
  end

  assign valid_out    = valid_q;
  assign opcode_out   = bundle_q.opcode;
  assign format_out   = bundle_q.fmt;
  assign rd_addr_out  = bundle_q.rd_addr;
  assign rs1_data_out = bundle_q.rs1_data;
  assign rs2_data_out = bundle_q.rs2_data;
  assign imm_out      = bundle_q.imm;
  assign npc_out      = bundle_q.npc;
  assign stall_out    = (state_q == STALL) || (state_q == HALTED);
  assign halt_out     = halt_q;

endmodule

// File: tb/tb_ins_decode_unit.sv
// Directed bench for ins_decode_unit: decode vector table plus hand-written
// sequences for reset, RAW stall, flush, freeze and halt.
module tb_ins_decode_unit;
  import ins_decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset, valid_in, freeze, flush_in, wb_enable_in;
  logic [31:0] ins_in, npc_in, wb_data_in;
  logic [4:0]  wb_addr_in;
  logic        valid_out, stall_out, halt_out;
  logic [5:0]  opcode_out;
  logic [1:0]  format_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rs1_data_out, rs2_data_out, imm_out, npc_out;

  always #5 clock = ~clock;

  ins_decode_unit dut (
    .clock(clock), .reset(reset), .ins_in(ins_in), .npc_in(npc_in),
    .valid_in(valid_in), .freeze(freeze), .flush_in(flush_in),
    .wb_enable_in(wb_enable_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
    .valid_out(valid_out), .opcode_out(opcode_out), .format_out(format_out),
    .rd_addr_out(rd_addr_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .imm_out(imm_out), .npc_out(npc_out), .stall_out(stall_out), .halt_out(halt_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_enable_in = 1'b1;
    wb_addr_in   = addr;
    wb_data_in   = data;
    tick();
    wb_enable_in = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] npc);
    ins_in   = ins;
    npc_in   = npc;
    valid_in = 1'b1;
  endtask

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {op, 2'b00, rd, rs1, rs2, 9'd0};
  endfunction
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [13:0] imm);
    return {op, 2'b01, rd, rs1, imm};
  endfunction
  function automatic logic [31:0] enc_b(logic [5:0] op, logic [4:0] rd, logic [4:0] rs1, logic [13:0] imm);
    return {op, 2'b10, rd, rs1, imm};
  endfunction
  function automatic logic [31:0] enc_j(logic [5:0] op, logic [23:0] imm);
    return {op, 2'b11, imm};
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] npc;
    logic [5:0]  op;
    logic [1:0]  fmt;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int nz;

    // Register contents used below: r1=11111111 r2=5 r3=80000000 r5=DEADBEEF
    // r6=12345678 r18=CAFEF00D; r0 write attempts must be ignored.
    vecs[0] = '{enc_i(6'h01, 5'd3, 5'd2, 14'h3FFF), 32'h100, 6'h01, 2'b01, 5'd3, 32'h5,        32'h0,        32'hFFFFFFFF};
    vecs[1] = '{enc_i(6'h02, 5'd8, 5'd1, 14'h1FFF), 32'h104, 6'h02, 2'b01, 5'd8, 32'h11111111, 32'h0,        32'h00001FFF};
    vecs[2] = '{enc_r(6'h03, 5'd9, 5'd5, 5'd6),     32'h108, 6'h03, 2'b00, 5'd9, 32'hDEADBEEF, 32'h12345678, 32'h0};
    vecs[3] = '{enc_r(6'h00, 5'd10, 5'd1, 5'd2),    32'h10C, 6'h00, 2'b00, 5'd0, 32'h11111111, 32'h5,        32'h0};
    vecs[4] = '{enc_b(6'h04, 5'd11, 5'd6, 14'h2401),32'h110, 6'h04, 2'b10, 5'd0, 32'h12345678, 32'hCAFEF00D, 32'hFFFFE401};
    vecs[5] = '{enc_j(6'h05, 24'h800000),           32'h114, 6'h05, 2'b11, 5'd0, 32'h0,        32'h0,        32'hFF800000};
    vecs[6] = '{enc_j(6'h05, 24'h7FFFFF),           32'h118, 6'h05, 2'b11, 5'd0, 32'h0,        32'h0,        32'h007FFFFF};
    vecs[7] = '{enc_r(6'h06, 5'd12, 5'd0, 5'd2),    32'h11C, 6'h06, 2'b00, 5'd12,32'h0,        32'h5,        32'h0};
    vecs[8] = '{enc_i(6'h07, 5'd0, 5'd6, 14'h0001), 32'h120, 6'h07, 2'b01, 5'd0, 32'h12345678, 32'h0,        32'h1};

    reset = 1'b1; valid_in = 1'b0; freeze = 1'b0; flush_in = 1'b0;
    wb_enable_in = 1'b0; wb_addr_in = '0; wb_data_in = '0; ins_in = '0; npc_in = '0;
    tick(); tick();
    reset = 1'b0;

    // Dirty every piece of state, park in STALL, then reset mid-stall.
    for (int i = 1; i < 32; i++) wb_write(5'(i), 32'hA000_0000 + 32'(i));
    issue(enc_r(6'h08, 5'd4, 5'd1, 5'd2), 32'h40); tick();
    issue(enc_r(6'h09, 5'd13, 5'd4, 5'd1), 32'h44); tick();
    valid_in = 1'b0;
    check("pre_reset_stall", 32'(stall_out), 32'd1);
    reset = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_opcode", 32'(opcode_out), 32'd0);
    check("rst_format", 32'(format_out), 32'd0);
    check("rst_rd", 32'(rd_addr_out), 32'd0);
    check("rst_rs1", rs1_data_out, 32'd0);
    check("rst_rs2", rs2_data_out, 32'd0);
    check("rst_imm", imm_out, 32'd0);
    check("rst_npc", npc_out, 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_halt", 32'(halt_out), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_sb", dut.sb_q, 32'd0);
    nz = 0;
    for (int i = 1; i < 32; i++) if (dut.u_rf.mem[i] !== 32'd0) nz++;
    check("rst_rf_nonzero_regs", 32'(nz), 32'd0);
    reset = 1'b0;

    wb_write(5'd1, 32'h11111111);
    wb_write(5'd2, 32'h5);
    wb_write(5'd3, 32'h80000000);
    wb_write(5'd5, 32'hDEADBEEF);
    wb_write(5'd6, 32'h12345678);
    wb_write(5'd18, 32'hCAFEF00D);
    wb_write(5'd0, 32'hFFFFFFFF);

    // Back-to-back decode vectors, none reading a register another one writes.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].ins, vecs[i].npc);
      tick();
      check($sformatf("v%0d_valid", i), 32'(valid_out), 32'd1);
      check($sformatf("v%0d_opcode", i), 32'(opcode_out), 32'(vecs[i].op));
      check($sformatf("v%0d_format", i), 32'(format_out), 32'(vecs[i].fmt));
      check($sformatf("v%0d_rd", i), 32'(rd_addr_out), 32'(vecs[i].rd));
      check($sformatf("v%0d_rs1", i), rs1_data_out, vecs[i].rs1);
      check($sformatf("v%0d_rs2", i), rs2_data_out, vecs[i].rs2);
      check($sformatf("v%0d_imm", i), imm_out, vecs[i].imm);
      check($sformatf("v%0d_npc", i), npc_out, vecs[i].npc);
      check($sformatf("v%0d_stall", i), 32'(stall_out), 32'd0);
    end
    valid_in = 1'b0;
    tick();
    check("idle_valid", 32'(valid_out), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    // RAW hazard on r4, resolved by write-back of A5.
    issue(enc_r(6'h08, 5'd4, 5'd1, 5'd2), 32'h200); tick();
    check("raw_prod_valid", 32'(valid_out), 32'd1);
    check("raw_prod_rd", 32'(rd_addr_out), 32'd4);
    issue(enc_r(6'h09, 5'd13, 5'd4, 5'd1), 32'h204); tick();
    issue(enc_r(6'h0A, 5'd14, 5'd1, 5'd2), 32'h208);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("raw_stall%0d", i), 32'(stall_out), 32'd1);
      check($sformatf("raw_bubble%0d", i), 32'(valid_out), 32'd0);
      if (i < 2) tick();
    end
    wb_write(5'd4, 32'hA5);
`ifndef WB_BYPASS_EN
    check("raw_extra_stall", 32'(stall_out), 32'd1);
    check("raw_extra_bubble", 32'(valid_out), 32'd0);
    tick();
`endif
    check("raw_cons_valid", 32'(valid_out), 32'd1);
    check("raw_cons_rs1", rs1_data_out, 32'hA5);
    check("raw_cons_rs2", rs2_data_out, 32'h11111111);
    check("raw_cons_rd", 32'(rd_addr_out), 32'd13);
    check("raw_cons_npc", npc_out, 32'h204);
    check("raw_release", 32'(stall_out), 32'd0);
    tick();
    check("raw_next_valid", 32'(valid_out), 32'd1);
    check("raw_next_rd", 32'(rd_addr_out), 32'd14);
    valid_in = 1'b0;
    tick();

    // Flush while stalled on r15: drop held and incoming, keep scoreboard.
    issue(enc_r(6'h0D, 5'd15, 5'd1, 5'd2), 32'h300); tick();
    check("fl_prod_valid", 32'(valid_out), 32'd1);
    issue(enc_r(6'h0E, 5'd16, 5'd15, 5'd2), 32'h304); tick();
    check("fl_stall", 32'(stall_out), 32'd1);
    issue(enc_r(6'h0F, 5'd21, 5'd1, 5'd2), 32'h308);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    check("fl_valid", 32'(valid_out), 32'd0);
    check("fl_stall_clr", 32'(stall_out), 32'd0);
    check("fl_state", 32'(dut.state_q), 32'(IDLE));
    check("fl_sb_r15", 32'(dut.sb_q[15]), 32'd1);
    tick();
    check("fl_after_valid", 32'(valid_out), 32'd0);

    // Freeze for 3 cycles with write-backs to r7 and r17 underneath.
    issue(enc_i(6'h0B, 5'd17, 5'd1, 14'h0003), 32'h400); tick();
    check("fz_pre_rd", 32'(rd_addr_out), 32'd17);
    issue(enc_r(6'h0C, 5'd19, 5'd7, 5'd1), 32'h404);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_enable_in = (i < 2);
      wb_addr_in   = (i == 0) ? 5'd7 : 5'd17;
      wb_data_in   = (i == 0) ? 32'h77 : 32'h17;
      tick();
      check($sformatf("fz%0d_valid", i), 32'(valid_out), 32'd1);
      check($sformatf("fz%0d_rd", i), 32'(rd_addr_out), 32'd17);
      check($sformatf("fz%0d_rs1", i), rs1_data_out, 32'h11111111);
      check($sformatf("fz%0d_imm", i), imm_out, 32'd3);
      check($sformatf("fz%0d_sb_r17", i), 32'(dut.sb_q[17]), 32'd1);
    end
    wb_enable_in = 1'b0;
    freeze = 1'b0;
    tick();
    check("fz_rel_valid", 32'(valid_out), 32'd1);
    check("fz_rel_rd", 32'(rd_addr_out), 32'd19);
    check("fz_rel_rs1", rs1_data_out, 32'h77);
    check("fz_rel_rs2", rs2_data_out, 32'h11111111);
    check("fz_rel_sb_r17", 32'(dut.sb_q[17]), 32'd0);
    valid_in = 1'b0;
    tick();

    // HALT: one valid bundle, then sticky halt/stall until reset.
    issue({OP_HALT, 2'b00, 5'd0, 5'd1, 5'd2, 9'd0}, 32'h500); tick();
    check("halt_valid", 32'(valid_out), 32'd1);
    check("halt_opcode", 32'(opcode_out), 32'h3F);
    check("halt_flag", 32'(halt_out), 32'd1);
    check("halt_stall", 32'(stall_out), 32'd1);
    issue(enc_i(6'h01, 5'd20, 5'd1, 14'h0005), 32'h504);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("halted%0d_valid", i), 32'(valid_out), 32'd0);
      check($sformatf("halted%0d_flag", i), 32'(halt_out), 32'd1);
      check($sformatf("halted%0d_stall", i), 32'(stall_out), 32'd1);
    end
    reset = 1'b1;
    tick();
    check("halt_rst_flag", 32'(halt_out), 32'd0);
    check("halt_rst_stall", 32'(stall_out), 32'd0);
    check("halt_rst_valid", 32'(valid_out), 32'd0);
    check("halt_rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    valid_in = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
